aes_io_ctrl: RTL and testbench
==============================

AES_IO_CTRL -- requirements
Module: aes_io_ctrl

Interface
REQ-001 Parameter START_DLY, default 2: cycles from acceptance of the 16th data byte to the core_start pulse; legal range 1..7.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  input byte valid.
REQ-005 in_data  input  8  input byte.
REQ-006 in_is_key  input  1  frame type, sampled with the first byte of a frame: 1 = 32-byte key frame, 0 = 16-byte data frame.
REQ-007 in_ready  output  1  controller accepts in_data this cycle.
REQ-008 wr_byte  output  8  byte forwarded to the 1-to-16 load registers.
REQ-009 key_lo_wr_en / key_hi_wr_en / data_wr_en  output  1 each  write strobes to the three 16-byte load registers.
REQ-010 core_start  output  1  one-cycle start pulse to the AES core.
REQ-011 core_done  input  1  one-cycle completion pulse from the core.
REQ-012 core_result  input  128  core output; byte k = core_result[8k+7:8k].
REQ-013 out_valid  output  1  output byte valid.
REQ-014 out_data  output  8  output byte.
REQ-015 out_ready  input  1  downstream accepts out_data.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 err  output  1  one-cycle pulse when a data frame arrives while no key is loaded.

Function
REQ-018 States SHALL be: IDLE, LOAD_KEY, LOAD_DATA, START, WAIT, UNLOAD.
REQ-019 A byte SHALL be accepted exactly on cycles with in_valid && in_ready; in_ready SHALL be high only in IDLE, LOAD_KEY and LOAD_DATA.
REQ-020 IDLE, accepted byte: go to LOAD_KEY if in_is_key=1, else LOAD_DATA; the byte counts as byte 0 of the frame.
REQ-021 A 5-bit byte counter SHALL track the frame; it resets to 0 at frame start and at frame end.
REQ-022 Each accepted key byte n SHALL drive wr_byte = in_data combinationally, with key_lo_wr_en for n in 0..15 and key_hi_wr_en for n in 16..31.
REQ-023 Each accepted data byte SHALL drive wr_byte = in_data with data_wr_en; at most one wr_en SHALL be high per cycle.
REQ-024 On acceptance of key byte 31, the controller SHALL set key_loaded=1 and return to IDLE.
REQ-025 On acceptance of data byte 15 with key_loaded=1, the controller SHALL enter START.
REQ-026 In START, the controller SHALL count START_DLY cycles after byte 15 was accepted, pulse core_start on that cycle, then enter WAIT.
REQ-027 With key_loaded=0, a data frame SHALL still consume 16 bytes with every wr_en low; err SHALL pulse on byte 0, and the controller SHALL return to IDLE after byte 15.
REQ-028 In WAIT, core_done SHALL latch core_result into a 128-bit output buffer and enter UNLOAD on the next cycle; core_done in any other state SHALL be ignored.
REQ-029 In UNLOAD, out_valid SHALL be 1 and out_data SHALL be buffer byte k, k = 0..15, starting at 0; k SHALL advance only on out_valid && out_ready.
REQ-030 out_data SHALL stay stable while out_valid && !out_ready.
REQ-031 After byte 15 is accepted, out_valid SHALL fall on the next cycle and the state SHALL return to IDLE; key_loaded SHALL remain 1, so further data frames reuse the key.
REQ-032 A new key frame SHALL clear key_loaded on its byte 0 and set it again on byte 31.
REQ-033 Bubbles (in_valid=0) mid-frame SHALL hold the state and counter indefinitely.

Reset
REQ-034 Asserting resetn low at any time, including mid-frame or in UNLOAD, SHALL asynchronously force: state=IDLE, counters=0, key_loaded=0, output buffer=0.
REQ-035 During reset, every output SHALL be 0.
REQ-036 The first accepted byte after reset release SHALL be treated as byte 0 of a new frame.

Structure
REQ-037 Package aes_io_pkg SHALL hold the state enum, KEY_BYTES=32, BLK_BYTES=16 and the START_DLY bounds.
REQ-038 The output serializer (buffer, byte index, valid/ready) SHALL be sub-module aes_ser16.

Verification
REQ-039 Key bytes 0x00..0x1F, then data bytes 0x20..0x2F, START_DLY=2 -> key_lo_wr_en x16, key_hi_wr_en x16, data_wr_en x16; core_start exactly 2 cycles after byte 0x2F.
REQ-040 Data frame with no prior key -> err on byte 0, no wr_en, no core_start; state back in IDLE after 16 bytes.
REQ-041 core_done with core_result=0x0F0E..0100 and out_ready toggling 1/0 -> out_data 0x00..0x0F in order, held stable while stalled.
REQ-042 resetn low after data byte 7 -> all outputs 0; a following data frame raises err (key lost).
REQ-043 Two data frames after one key -> two core_start pulses; key_*_wr_en never re-asserts.
REQ-044 core_done injected in IDLE/LOAD_DATA -> ignored; out_valid stays 0.

Source files
------------

// File: rtl/aes_io_pkg.sv
// -----------------------------------------------------------------------------
// aes_io_pkg
//   Shared definitions for the AES byte-stream I/O controller: controller
//   state encoding, frame sizes in bytes and the legal start-delay range.
// -----------------------------------------------------------------------------
package aes_io_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_KEY,
      LOAD_DATA,
      START,
      WAIT,
      UNLOAD
   } state_t;

   localparam int unsigned KEY_BYTES     = 32;
   localparam int unsigned BLK_BYTES     = 16;
   localparam int unsigned START_DLY_MIN = 1;
   localparam int unsigned START_DLY_MAX = 7;

endpackage

// File: rtl/aes_ser16.sv
// -----------------------------------------------------------------------------
// aes_ser16
//   Captures a 128-bit AES result and streams it out as 16 bytes, byte 0
//   (bits 7:0) first, under a valid/ready handshake.
//
//   clk, resetn     clock, asynchronous active-low reset
//   i_load          capture i_result and start streaming
//   i_result[127:0] block to stream
//   i_out_ready     downstream accepts o_out_data
//   o_out_valid     o_out_data is valid
//   o_out_data[7:0] current byte (0 when not valid)
//   o_last          final byte is being accepted this cycle
// -----------------------------------------------------------------------------
module aes_ser16 (
   input  logic         clk,
   input  logic         resetn,
   input  logic         i_load,
   input  logic [127:0] i_result,
   input  logic         i_out_ready,
   output logic         o_out_valid,
   output logic [7:0]   o_out_data,
   output logic         o_last
);

   logic [127:0] r_buf;
   logic [3:0]   r_idx;
   logic         r_valid;
   logic         w_accept;

   assign w_accept = r_valid && i_out_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_buf   <= '0;
         r_idx   <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_buf   <= i_result;
         r_idx   <= '0;
         r_valid <= 1'b1;
      end else if (w_accept) begin
         // index wraps back to 0 after byte 15, ready for the next block
         r_idx <= r_idx + 4'd1;
         if (r_idx == 4'd15)
            r_valid <= 1'b0;
      end
   end

   assign o_out_valid = r_valid;
   assign o_out_data  = r_valid ? r_buf[{r_idx, 3'b000} +: 8] : '0;
   assign o_last      = w_accept && (r_idx == 4'd15);

endmodule

// File: rtl/aes_io_ctrl.sv
// -----------------------------------------------------------------------------
// aes_io_ctrl
//   Byte-stream front end for an AES core. Loads a 32-byte key frame into the
//   key_lo/key_hi registers and 16-byte data frames into the data register,
//   starts the core START_DLY cycles after the last data byte, then streams
//   the 16-byte result out through aes_ser16.
//
//   clk, resetn            clock, asynchronous active-low reset
//   in_valid/in_data/in_is_key/in_ready   input byte stream (in_is_key is
//                          sampled on the first byte of a frame)
//   wr_byte, key_lo_wr_en, key_hi_wr_en, data_wr_en   load-register writes
//   core_start, core_done, core_result    AES core handshake
//   out_valid/out_data/out_ready          output byte stream
//   busy                   controller not idle
//   err                    data frame received with no key loaded
// -----------------------------------------------------------------------------
module aes_io_ctrl
   import aes_io_pkg::*;
#(
   parameter int unsigned START_DLY = 2
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   input  logic         in_is_key,
   output logic         in_ready,
   output logic [7:0]   wr_byte,
   output logic         key_lo_wr_en,
   output logic         key_hi_wr_en,
   output logic         data_wr_en,
   output logic         core_start,
   input  logic         core_done,
   input  logic [127:0] core_result,
   output logic         out_valid,
   output logic [7:0]   out_data,
   input  logic         out_ready,
   output logic         busy,
   output logic         err
);

   // out-of-range settings are clamped into the supported window
   localparam int unsigned LP_DLY_I =
      (START_DLY < START_DLY_MIN) ? START_DLY_MIN :
      (START_DLY > START_DLY_MAX) ? START_DLY_MAX : START_DLY;
   localparam logic [2:0] LP_DLY = 3'(LP_DLY_I);

   state_t     r_state, w_next;
   logic [4:0] r_cnt;
   logic [2:0] r_dly;
   logic       r_key_loaded;

   logic w_ready, w_acc, w_key_byte, w_data_byte;
   logic w_last_key, w_last_data, w_load, w_ser_last;

   // in_ready is gated by resetn so every output reads 0 while in reset
   assign w_ready     = resetn && (r_state == IDLE || r_state == LOAD_KEY ||
                                   r_state == LOAD_DATA);
   assign w_acc       = in_valid && w_ready;
   assign w_key_byte  = w_acc && ((r_state == IDLE && in_is_key) || r_state == LOAD_KEY);
   assign w_data_byte = w_acc && ((r_state == IDLE && !in_is_key) || r_state == LOAD_DATA);
   assign w_last_key  = w_acc && (r_state == LOAD_KEY)  && (r_cnt == 5'(KEY_BYTES - 1));
   assign w_last_data = w_acc && (r_state == LOAD_DATA) && (r_cnt == 5'(BLK_BYTES - 1));
   assign w_load      = core_done && (r_state == WAIT);

   // state register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         r_state <= IDLE;
      else
         r_state <= w_next;
   end

   // next-state logic
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:      if (w_acc) w_next = in_is_key ? LOAD_KEY : LOAD_DATA;
         LOAD_KEY:  if (w_last_key) w_next = IDLE;
         LOAD_DATA: if (w_last_data) w_next = r_key_loaded ? START : IDLE;
         START:     if (r_dly == LP_DLY) w_next = WAIT;
         WAIT:      if (core_done) w_next = UNLOAD;
         UNLOAD:    if (w_ser_last) w_next = IDLE;
         default:   w_next = IDLE;
      endcase
   end

   // outputs
   always_comb begin
      in_ready     = w_ready;
      wr_byte      = w_acc ? in_data : '0;
      key_lo_wr_en = w_key_byte && (r_cnt < 5'(BLK_BYTES));
      key_hi_wr_en = w_key_byte && (r_cnt >= 5'(BLK_BYTES));
      data_wr_en   = w_data_byte && r_key_loaded;
      err          = w_data_byte && !r_key_loaded && (r_state == IDLE);
      core_start   = (r_state == START) && (r_dly == LP_DLY);
      busy         = (r_state != IDLE);
   end

   // byte counter, start-delay counter and key status
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt        <= '0;
         r_dly        <= '0;
         r_key_loaded <= 1'b0;
      end else begin
         if (w_last_key || w_last_data)
            r_cnt <= '0;
         else if (w_acc)
            r_cnt <= r_cnt + 5'd1;

         // the first START cycle is already one cycle after the last byte
         if (r_state == START)
            r_dly <= r_dly + 3'd1;
         else
            r_dly <= 3'd1;

         if (w_acc && r_state == IDLE && in_is_key)
            r_key_loaded <= 1'b0;
         else if (w_last_key)
            r_key_loaded <= 1'b1;
      end
   end

   aes_ser16 u_ser (
      .clk         (clk),
      .resetn      (resetn),
      .i_load      (w_load),
      .i_result    (core_result),
      .i_out_ready (out_ready),
      .o_out_valid (out_valid),
      .o_out_data  (out_data),
      .o_last      (w_ser_last)
   );

endmodule

// File: tb/tb_aes_io_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_io_ctrl
//   Self-checking bench for aes_io_ctrl. A frame-level model (frame kind,
//   byte position, key status) predicts the write strobes and err for every
//   accepted byte; frame tasks check start latency, the unloaded result and
//   the idle/busy behaviour around them.
// -----------------------------------------------------------------------------
module tb_aes_io_ctrl;

   localparam int unsigned DLY = 2;

   logic         clk, resetn;
   logic         in_valid, in_is_key, in_ready;
   logic [7:0]   in_data, wr_byte, out_data;
   logic         key_lo_wr_en, key_hi_wr_en, data_wr_en;
   logic         core_start, core_done, out_valid, out_ready, busy, err;
   logic [127:0] core_result;

   aes_io_ctrl #(.START_DLY(DLY)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_is_key    (in_is_key),
      .in_ready     (in_ready),
      .wr_byte      (wr_byte),
      .key_lo_wr_en (key_lo_wr_en),
      .key_hi_wr_en (key_hi_wr_en),
      .data_wr_en   (data_wr_en),
      .core_start   (core_start),
      .core_done    (core_done),
      .core_result  (core_result),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .busy         (busy),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int last_acc = 0;
   int n_lo = 0, n_hi = 0, n_data = 0, n_err = 0, n_start = 0;

   // frame model: 0 = between frames, 1 = key frame, 2 = data frame
   int m_kind = 0;
   int m_idx  = 0;
   bit m_key  = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   always @(negedge clk or negedge resetn) begin
      if (!resetn) begin
         m_kind = 0;
         m_idx  = 0;
         m_key  = 0;
      end else begin
         bit e_lo, e_hi, e_data, e_err;
         e_lo = 0; e_hi = 0; e_data = 0; e_err = 0;
         if (in_valid && in_ready) begin
            if (m_kind == 0) begin
               m_kind = in_is_key ? 1 : 2;
               m_idx  = 0;
               if (in_is_key) m_key = 0;
            end
            if (m_kind == 1) begin
               e_lo = (m_idx < 16);
               e_hi = (m_idx >= 16);
            end else begin
               e_data = m_key;
               e_err  = !m_key && (m_idx == 0);
            end
            m_idx++;
            if (m_kind == 1 && m_idx == 32) begin
               m_key  = 1;
               m_kind = 0;
            end else if (m_kind == 2 && m_idx == 16) begin
               m_kind = 0;
            end
         end
         check("strobes", 128'({key_lo_wr_en, key_hi_wr_en, data_wr_en, err}),
               128'({e_lo, e_hi, e_data, e_err}));
         if (key_lo_wr_en || key_hi_wr_en || data_wr_en)
            check("wr_byte", 128'(wr_byte), 128'(in_data));
         n_lo    += int'(key_lo_wr_en);
         n_hi    += int'(key_hi_wr_en);
         n_data  += int'(data_wr_en);
         n_err   += int'(err);
         n_start += int'(core_start);
      end
   end

   function automatic logic [127:0] r128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic k);
      bit got;
      got = 0;
      in_valid  = 1'b1;
      in_data   = b;
      in_is_key = k;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            last_acc = cyc;
         end
         tick();
      end
      in_valid  = 1'b0;
      in_data   = 8'($urandom);
      in_is_key = 1'($urandom);
      if (!got) check("accept_timeout", 0, 1);
   endtask

   task automatic send_frame(input logic k, input logic [255:0] bytes, input bit spurious);
      int nb;
      nb = k ? 32 : 16;
      for (int i = 0; i < nb; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         if (spurious && i == 8) begin
            core_done   = 1'b1;
            core_result = r128();
            @(negedge clk);
            check("spur_load_ov", 128'(out_valid), 0);
            tick();
            core_done = 1'b0;
            @(negedge clk);
            check("spur_load_ov2", 128'(out_valid), 0);
            tick();
         end
         send_byte(bytes[8*i +: 8], k);
      end
   endtask

   task automatic key_frame(input logic [255:0] kb);
      int l0, h0;
      l0 = n_lo;
      h0 = n_hi;
      send_frame(1'b1, kb, 0);
      check("key_lo_cnt", 128'(n_lo - l0), 16);
      check("key_hi_cnt", 128'(n_hi - h0), 16);
      @(negedge clk);
      check("key_idle_busy", 128'(busy), 0);
      tick();
   endtask

   task automatic run_block(input logic [127:0] res, input bit toggle);
      int s0, sc, k;
      bit seen, stop;
      s0 = n_start;
      seen = 0;
      sc = 0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         check("busy_start", 128'(busy), 1);
         check("rdy_start", 128'(in_ready), 0);
         if (core_start) begin
            seen = 1;
            sc = cyc;
         end
         tick();
      end
      if (!seen) check("start_timeout", 0, 1);
      else check("start_lat", 128'(sc - last_acc), 128'(DLY));
      repeat ($urandom_range(0, 3)) begin
         @(negedge clk);
         check("wait_ov", 128'(out_valid), 0);
         check("wait_rdy", 128'(in_ready), 0);
         tick();
      end
      core_done   = 1'b1;
      core_result = res;
      tick();
      core_done   = 1'b0;
      core_result = r128();
      k = 0;
      stop = 0;
      for (int n = 0; n < 200 && k < 16 && !stop; n++) begin
         out_ready = toggle ? (n % 2 == 0) : 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!out_valid) begin
            check("unl_valid", 0, 1);
            stop = 1;
         end else begin
            check(out_ready ? "out_byte" : "out_stall", 128'(out_data), 128'(res[8*k +: 8]));
            check("unl_rdy", 128'(in_ready), 0);
            if (out_ready) k++;
         end
         tick();
      end
      if (k < 16 && !stop) check("unload_timeout", 0, 1);
      out_ready = 1'b0;
      @(negedge clk);
      check("ov_fall", 128'(out_valid), 0);
      check("busy_end", 128'(busy), 0);
      check("start_count", 128'(n_start - s0), 1);
      tick();
   endtask

   task automatic data_frame(input logic [127:0] d, input logic [127:0] res,
                             input bit toggle, input bit spur);
      bit had_key;
      int s0, e0, d0;
      had_key = m_key;
      s0 = n_start;
      e0 = n_err;
      d0 = n_data;
      send_frame(1'b0, {128'b0, d}, spur);
      if (had_key) begin
         run_block(res, toggle);
      end else begin
         repeat (DLY + 3) begin
            @(negedge clk);
            check("nokey_start", 128'(core_start), 0);
            check("nokey_busy", 128'(busy), 0);
            check("nokey_rdy", 128'(in_ready), 1);
            tick();
         end
         check("nokey_err_cnt", 128'(n_err - e0), 1);
         check("nokey_start_cnt", 128'(n_start - s0), 0);
      end
      check("data_cnt", 128'(n_data - d0), had_key ? 128'd16 : 128'd0);
   endtask

   function automatic logic [23:0] all_outs();
      return {in_ready, wr_byte, key_lo_wr_en, key_hi_wr_en, data_wr_en,
              core_start, out_valid, out_data, busy, err};
   endfunction

   task automatic do_reset();
      #2;
      resetn   = 1'b0;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      #1;
      check("rst_outs_async", 128'(all_outs()), 0);
      @(negedge clk);
      check("rst_outs", 128'(all_outs()), 0);
      tick();
      in_valid = 1'b0;
      resetn   = 1'b1;
      tick();
   endtask

   initial begin
      logic [255:0] kb;
      logic [127:0] db, res;
      int l0, h0;
      resetn = 1'b0;
      in_valid = 1'b0; in_data = '0; in_is_key = 1'b0;
      core_done = 1'b0; core_result = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      in_valid = 1'b1;
      #1;
      check("reset_outs", 128'(all_outs()), 0);
      in_valid = 1'b0;
      tick();
      resetn = 1'b1;
      tick();

      // data frame before any key: err, no writes, no start
      data_frame(r128(), '0, 0, 0);

      // key 00..1F, data 20..2F, result bytes 00..0F, ready toggling
      for (int i = 0; i < 32; i++) kb[8*i +: 8] = 8'(i);
      for (int i = 0; i < 16; i++) db[8*i +: 8] = 8'(32 + i);
      for (int i = 0; i < 16; i++) res[8*i +: 8] = 8'(i);
      key_frame(kb);
      l0 = n_lo;
      h0 = n_hi;
      data_frame(db, res, 1, 0);

      // second frame reuses the key; stray core_done mid-frame is ignored
      data_frame(r128(), r128(), 0, 1);
      check("key_lo_reuse", 128'(n_lo - l0), 0);
      check("key_hi_reuse", 128'(n_hi - h0), 0);

      // stray core_done while idle
      core_done = 1'b1;
      core_result = r128();
      tick();
      core_done = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("idle_spur_ov", 128'(out_valid), 0);
         check("idle_spur_busy", 128'(busy), 0);
         tick();
      end

      // reset after data byte 7 loses the key
      for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b0);
      do_reset();
      data_frame(r128(), '0, 0, 0);

      // random mix of frames
      for (int it = 0; it < 8; it++) begin
         if ($urandom_range(0, 2) == 0 || !m_key)
            key_frame({r128(), r128()});
         else
            data_frame(r128(), r128(), 0, 1'($urandom_range(0, 1)));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      n_errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $fatal(1);
   end

endmodule
